// File: rtl/sensor_uart_sched.sv
// rtl/sensor_uart_sched.sv - round-robin sensor packet scheduler feeding an 8N1 UART TX
// Grants one channel at a time and frames its sample as SYNC, channel, hi, lo, xor.
module sensor_uart_sched #(
  parameter int         N_CH = 4,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      i_req,
  input  logic [16*N_CH-1:0]   i_sample,
  output logic [N_CH-1:0]      o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic                 o_pkt_active,
  output logic [15:0]          o_pkt_count
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_ch;
  logic [15:0]     r_sample;
  logic [2:0]      r_idx;
  logic [N_CH-1:0] r_ack;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_pkt_active;
  logic [15:0]     r_pkt_count;

  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic [IW-1:0]   w_cand;
  logic [15:0]     w_gnt_sample;
  logic [7:0]      w_ch_byte;
  logic [7:0]      w_byte;

  // Walk offsets from farthest to nearest so the channel right after r_last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int off = N_CH; off >= 1; off--) begin
      w_cand = IW'((int'(r_last) + off) % N_CH);
      if (i_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt_sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_gnt_idx == IW'(k)) w_gnt_sample = i_sample[16*k +: 16];
    end
  end

  assign w_ch_byte = 8'(r_ch);

  always_comb begin
    case (r_idx)
      3'd0:    w_byte = SYNC;
      3'd1:    w_byte = w_ch_byte;
      3'd2:    w_byte = r_sample[15:8];
      3'd3:    w_byte = r_sample[7:0];
      default: w_byte = SYNC ^ w_ch_byte ^ r_sample[15:8] ^ r_sample[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= IW'(N_CH - 1);
      r_ch         <= '0;
      r_sample     <= '0;
      r_idx        <= '0;
      r_ack        <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_pkt_active <= 1'b0;
      r_pkt_count  <= 16'h0000;
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_ack[w_gnt_idx] <= 1'b1;
            r_last           <= w_gnt_idx;
            r_ch             <= w_gnt_idx;
            r_sample         <= w_gnt_sample;
            r_idx            <= 3'd0;
            r_pkt_active     <= 1'b1;
            r_state          <= S_SEND;
          end
        end
        S_SEND: begin
          if (!i_tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (i_tx_busy) r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!i_tx_busy) begin
            if (r_idx == 3'd4) begin
              r_pkt_count  <= r_pkt_count + 16'd1;
              r_pkt_active <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_pkt_active = r_pkt_active;
  assign o_pkt_count  = r_pkt_count;

endmodule

// File: doc/sensor_uart_sched.md
# sensor_uart_sched

Round-robin packet scheduler that shares the single 8N1 UART transmitter among N sensor channels. Each channel offers a 16-bit sample. The scheduler grants one channel at a time, latches its sample, and frames it as a 5-byte packet. It then feeds the packet byte-by-byte into the UART transmitter's `start`/`data`/`busy` interface. It sits between the sensor front-ends and the UART TX in the hub top level.

## Interface
Parameters:
- `N_CH`, 4 — number of sensor channels, 2..8.
- `SYNC`, 8'hA5 — packet sync byte.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_CH  per-channel request, level. Held until the matching `ack`.
- `sample`  in  16*N_CH  flattened samples; channel k is `sample[16k+15:16k]`.
- `ack`  out  N_CH  one-cycle pulse; the channel's sample has been latched.
- `tx_start`  out  1  one-cycle start pulse to the UART TX.
- `tx_data`  out  8  byte to the UART TX. Stable from the `tx_start` cycle until that byte completes.
- `tx_busy`  in  1  UART TX busy flag.
- `pkt_active`  out  1  high from grant until the last byte completes.
- `pkt_count`  out  16  number of completed packets; wraps 0xFFFF→0x0000.

## Operation
- Packet byte order:
  - 0: `SYNC`
  - 1: channel index, zero-extended to 8 bits
  - 2: sample[15:8]
  - 3: sample[7:0]
  - 4: XOR of bytes 0..3
- Sample and channel index are captured at grant. Later changes on `sample` do not affect the packet in flight.
- Arbitration is round-robin. The search starts at `last+1` mod N_CH and takes the first asserted `req`. `last` is updated to the granted channel. The reset value of `last` is N_CH-1, so channel 0 has top priority first.
- Requests asserted during a packet wait; they are not lost while `req` is held.
- A requester that keeps `req` high after `ack` is treated as a new request and competes again.
- FSM states:
  - IDLE: if `|req`, grant, pulse `ack[g]`, latch the sample, set byte idx=0, → SEND.
  - SEND: if `!tx_busy`, set `tx_start`=1 and `tx_data`=byte[idx], → WAIT_HI. If `tx_busy`=1, stay.
  - WAIT_HI: `tx_start`=0. When `tx_busy`=1 → WAIT_LO.
  - WAIT_LO: when `tx_busy`=0:
    - if idx==4: increment `pkt_count` → IDLE.
    - else: idx+1 → SEND.
- `pkt_active` = (state != IDLE).
- Reset values: state=IDLE, `ack`=0, `tx_start`=0, `tx_data`=8'h00, `pkt_active`=0, `pkt_count`=0, `last`=N_CH-1.
- Reset mid-packet aborts immediately. The remaining bytes are not sent and `pkt_count` is not incremented. The granted channel has already been acked; its sample is lost.

## Timing
- All outputs are registered.
- Grant latency: with `req` high at edge E in IDLE, `ack` is high during the cycle after E and `pkt_active` rises with it.
- `tx_start` is high for exactly one cycle, the cycle after the SEND edge. The UART TX samples it on the next edge and raises `busy` one cycle later. WAIT_HI therefore lasts at most 2 cycles against a conforming UART TX.
- Per-byte overhead beyond the UART frame time is ≤4 cycles. Packet time ≈ 5·10·DIV + 20 cycles.
- `tx_start` is never asserted while `tx_busy`=1.
- At most one `ack` bit is high in any cycle, and at most one `ack` per packet.

## Test plan
Bench setup: UART TX instantiated with DIV=4; a serial monitor decodes its `tx` line.
- Reset, then `req`=4'b0010 with sample1=16'h1234 → `ack`=4'b0010 pulse once. Decoded bytes A5 01 12 34 82. `pkt_count`=1 and `pkt_active` falls after the final stop bit.
- `req`=4'b1111 held, samples k→16'h0k0k → packets in channel order 0,1,2,3,0. Exactly one `ack` per packet.
- Channel 3 sends, then `req`=4'b1001 arrives during that packet → channel 0 is served next (wrap-around). Checksum A5^00^00^00=A5.
- `sample` changed one cycle after `ack` → the transmitted payload equals the value present at `ack`.
- Pulse `rst_n` low during byte 2 → `tx_start`=0, `pkt_active`=0, `pkt_count` unchanged. `tx` returns idle high, and a new request then produces a full 5-byte packet.
- Force `pkt_count`=16'hFFFF, send one packet → `pkt_count`=16'h0000.
